// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Sequential instruction fetch unit. It holds a registered fetch PC, reads
//   one word per cycle from a combinational instruction memory, and buffers
//   {pc, instr} pairs in a 2-entry FIFO toward decode with valid/ready
//   handshaking. A redirect flushes the FIFO and restarts fetch at the target.
//
// Configuration:
//   FETCH_ALIGN_CHECK_EN - when defined, a redirect whose target has
//   bits [1:0] != 0 is not taken. Instead the unit enters a TRAP state and
//   raises O_misaligned until an aligned redirect arrives. When undefined,
//   the low two target bits are ignored.
//
// Parameters:
//   RESET_PC  - first fetch address after reset
//   MEM_BYTES - instruction memory size in bytes (power of two, >= 8)
//
// Ports:
//   I_clk          in   clock, rising edge
//   I_rst_n        in   asynchronous active-low reset
//   O_imem_address out  byte address to instruction memory (registered)
//   I_imem_data    in   little-endian word at O_imem_address, same cycle
//   I_redirect     in   branch/jump redirect strobe
//   I_redirect_pc  in   redirect target byte address
//   O_valid        out  head instruction available to decode
//   I_ready        in   decode accepts the head instruction
//   O_instr        out  head instruction word
//   O_pc           out  byte address of O_instr
//   O_misaligned   out  misaligned-redirect trap flag (FETCH_ALIGN_CHECK_EN only)
// -----------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_BYTES = 1024
) (
   input  logic        I_clk,
   input  logic        I_rst_n,
   output logic [31:0] O_imem_address,
   input  logic [31:0] I_imem_data,
   input  logic        I_redirect,
   input  logic [31:0] I_redirect_pc,
   output logic        O_valid,
   input  logic        I_ready,
   output logic [31:0] O_instr,
   output logic [31:0] O_pc
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic        O_misaligned
`endif
);

   // Redirect targets are folded into the memory and forced word aligned.
   localparam logic [31:0] REDIRECT_MASK = 32'(MEM_BYTES - 1) & ~32'h3;
   localparam logic [31:0] WRAP_PC       = 32'(MEM_BYTES - 4);

`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic [1:0] {ST_FETCH = 2'd0, ST_FULL = 2'd1, ST_TRAP = 2'd2} state_t;
`else
   typedef enum logic {ST_FETCH = 1'b0, ST_FULL = 1'b1} state_t;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_pc_inc;
   entry_t      fifo [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;

   logic        push;
   logic        pop;
   logic        trap_req;

   assign O_imem_address = fetch_pc;
   assign O_valid        = (count != 2'd0);
   assign O_instr        = fifo[rd_ptr].instr;
   assign O_pc           = fifo[rd_ptr].pc;
`ifdef FETCH_ALIGN_CHECK_EN
   assign O_misaligned   = (state == ST_TRAP);
`endif

   assign fetch_pc_inc = (fetch_pc == WRAP_PC) ? 32'h0 : fetch_pc + 32'd4;

   // NOTE: every variable written here gets a default first, so no path
   // through the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      pop        = O_valid && I_ready;
      push       = 1'b0;
      trap_req   = 1'b0;
      state_next = state;
`ifdef FETCH_ALIGN_CHECK_EN
      trap_req   = I_redirect && (I_redirect_pc[1:0] != 2'b00);
`endif

      // FETCH always has a free slot; FULL only refills behind a pop.
      unique case (state)
         ST_FETCH: push = !I_redirect;
         ST_FULL:  push = !I_redirect && pop;
         default:  push = 1'b0;
      endcase

      if (I_redirect) begin
`ifdef FETCH_ALIGN_CHECK_EN
         state_next = trap_req ? ST_TRAP : ST_FETCH;
`else
         state_next = ST_FETCH;
`endif
      end else if (state == ST_FETCH && push && !pop && count == 2'd1) begin
         state_next = ST_FULL;
      end else if (state == ST_FULL && pop && !push) begin
         state_next = ST_FETCH;
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only,
   // so every register samples the pre-edge values of the others.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state    <= ST_FETCH;
         fetch_pc <= RESET_PC;
         count    <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         // NOTE: the FIFO storage is reset too; it is only two entries and
         // O_instr/O_pc are read straight from it, so they must read zero
         // while reset is held.
         fifo[0]  <= '0;
         fifo[1]  <= '0;
      end else begin
         state <= state_next;
         if (I_redirect) begin
            // A coinciding transfer has already been taken by decode; every
            // other entry is dropped along with the pointers.
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            if (!trap_req) begin
               fetch_pc <= I_redirect_pc & REDIRECT_MASK;
            end
         end else begin
            if (push) begin
               fifo[wr_ptr] <= '{pc: fetch_pc, instr: I_imem_data};
               wr_ptr       <= ~wr_ptr;
               fetch_pc     <= fetch_pc_inc;
            end
            if (pop) begin
               rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
         end
      end
   end

endmodule
